// File: rtl/ram_stream_ctrl.sv
// Byte-stream command engine: parses a 5-byte header (CMD, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO) from rx,
// then writes the payload into a single-port byte RAM or streams RAM contents out on tx.
module ram_stream_ctrl #(
  parameter int VECTOR_LENGTH = 512,
  parameter int ADDR_WIDTH    = $clog2(VECTOR_LENGTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  ram_clke_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [7:0]            ram_mask_o,
  output logic [7:0]            ram_wdata_o,
  input  logic [7:0]            ram_rdata_i,
  output logic                  busy_o
);

  localparam logic [7:0]            CMD_WR    = 8'h57;
  localparam logic [7:0]            CMD_RD    = 8'h52;
  localparam logic [31:0]           VLEN      = VECTOR_LENGTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(VECTOR_LENGTH - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, WR_DATA, RD_REQ, RD_WAIT, RD_OUT
  } state_t;

  state_t                state, state_nxt;
  logic                  is_rd;
  logic [7:0]            addr_hi;
  logic [ADDR_WIDTH-1:0] addr, wr_addr, start_addr, addr_trunc, addr_inc;
  logic [15:0]           cnt, len_full;
  logic [7:0]            wr_data;
  logic                  wr_pend;
  logic                  rx_hs, tx_hs, rd_state;

  assign rd_state   = (state == RD_REQ) || (state == RD_WAIT) || (state == RD_OUT);
  assign rx_ready_o = ~rst_i & ~rd_state;
  assign tx_valid_o = (state == RD_OUT);
  assign busy_o     = (state != IDLE);
  assign rx_hs      = rx_valid_i & rx_ready_o;
  assign tx_hs      = tx_valid_o & tx_ready_i;

  // An out-of-range start address restarts at the bottom of the RAM.
  assign addr_trunc = ADDR_WIDTH'({addr_hi, rx_data_i});
  assign start_addr = (32'(addr_trunc) >= VLEN) ? '0 : addr_trunc;
  assign addr_inc   = (addr == LAST_ADDR) ? '0 : addr + ADDR_WIDTH'(1);
  assign len_full   = {cnt[15:8], rx_data_i};

  // A write lands one cycle after its rx handshake; reset suppresses any pending write.
  assign ram_we_o    = wr_pend & ~rst_i;
  assign ram_clke_o  = ram_we_o | ((state == RD_REQ) & ~rst_i);
  assign ram_addr_o  = wr_pend ? wr_addr : addr;
  assign ram_mask_o  = 8'h00;
  assign ram_wdata_o = wr_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rx_hs && (rx_data_i == CMD_WR || rx_data_i == CMD_RD)) state_nxt = ADDR_HI;
      ADDR_HI: if (rx_hs) state_nxt = ADDR_LO;
      ADDR_LO: if (rx_hs) state_nxt = LEN_HI;
      LEN_HI:  if (rx_hs) state_nxt = LEN_LO;
      LEN_LO: begin
        if (rx_hs) begin
          if (len_full == 16'd0) state_nxt = IDLE;
          else if (is_rd)        state_nxt = RD_REQ;
          else                   state_nxt = WR_DATA;
        end
      end
      WR_DATA: if (rx_hs && cnt == 16'd1) state_nxt = IDLE;
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = RD_OUT;
      RD_OUT:  if (tx_hs) state_nxt = (cnt == 16'd1) ? IDLE : RD_REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      is_rd     <= 1'b0;
      addr_hi   <= '0;
      addr      <= '0;
      cnt       <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_pend   <= 1'b0;
      tx_data_o <= '0;
    end else begin
      wr_pend <= 1'b0;
      case (state)
        IDLE:    if (rx_hs) is_rd <= (rx_data_i == CMD_RD);
        ADDR_HI: if (rx_hs) addr_hi <= rx_data_i;
        ADDR_LO: if (rx_hs) addr <= start_addr;
        LEN_HI:  if (rx_hs) cnt[15:8] <= rx_data_i;
        LEN_LO:  if (rx_hs) cnt <= len_full;
        WR_DATA: begin
          if (rx_hs) begin
            wr_pend <= 1'b1;
            wr_addr <= addr;
            wr_data <= rx_data_i;
            addr    <= addr_inc;
            cnt     <= cnt - 16'd1;
          end
        end
        RD_WAIT: tx_data_o <= ram_rdata_i;
        RD_OUT: begin
          if (tx_hs) begin
            cnt  <= cnt - 16'd1;
            addr <= addr_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Self-checking bench for ram_stream_ctrl: behavioural RAM, bus monitor, and a byte-array reference model
// driven by directed scenarios plus randomized commands.
module tb_ram_stream_ctrl;
  localparam int VL = 512;
  localparam int AW = 9;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [7:0]    rx_data_i = 8'h00;
  logic          rx_valid_i = 1'b0;
  logic          rx_ready_o;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i = 1'b1;
  logic          ram_clke_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [7:0]    ram_mask_o, ram_wdata_o;
  logic [7:0]    ram_rdata_i = 8'h00;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ram_stream_ctrl #(.VECTOR_LENGTH(VL)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .ram_clke_o(ram_clke_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_mask_o(ram_mask_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
    .busy_o(busy_o)
  );

  // Attached RAM (environment) and the reference byte array the expectations come from.
  logic [7:0] mem [VL] = '{default: 8'h00};
  logic [7:0] ref_mem [VL] = '{default: 8'h00};

  always @(posedge clk_i) begin
    if (ram_clke_o) begin
      if (ram_we_o) mem[ram_addr_o] <= (mem[ram_addr_o] & ram_mask_o) | (ram_wdata_o & ~ram_mask_o);
      else          ram_rdata_i <= mem[ram_addr_o];
    end
  end

  // Append-only bus logs; tests look at entries past a saved base index.
  int cyc = 0;
  int wr_a_q[$], wr_d_q[$], wr_c_q[$], rxh_q[$], tx_q[$];
  int strobes = 0, we_in_rst = 0, mask_bad = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (ram_clke_o || ram_we_o) strobes++;
    if (rst_i && ram_we_o) we_in_rst++;
    if (ram_mask_o !== 8'h00) mask_bad++;
    if (!rst_i && ram_clke_o && ram_we_o) begin
      wr_a_q.push_back(int'(ram_addr_o));
      wr_d_q.push_back(int'(ram_wdata_o));
      wr_c_q.push_back(cyc);
    end
    if (rx_valid_i && rx_ready_o) rxh_q.push_back(cyc);
    if (tx_valid_o && tx_ready_i) tx_q.push_back(int'(tx_data_o));
  end

  function automatic int start_of(input int a16);
    int a;
    a = a16 % (1 << AW);
    if (a >= VL) a = 0;
    return a;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t;
    rx_data_i = b; rx_valid_i = 1'b1; t = 0;
    @(negedge clk_i);
    while (!rx_ready_o && t < 100) begin @(negedge clk_i); t++; end
    if (!rx_ready_o) begin checks++; errors++; $display("FAIL rx_timeout ready=%b required=1", rx_ready_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] a, input logic [15:0] n);
    send_byte(cmd); send_byte(a[15:8]); send_byte(a[7:0]); send_byte(n[15:8]); send_byte(n[7:0]);
  endtask

  task automatic rx_idle(input int n);
    rx_valid_i = 1'b0;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic run_read(input int len, input int stall_idx, output int lat, output int stall_bad, output int rdy_bad);
    logic [7:0] d0;
    lat = 0; stall_bad = 0; rdy_bad = 0;
    for (int i = 0; i < len; i++) begin
      int t;
      t = 0;
      tx_ready_i = (i == stall_idx) ? 1'b0 : 1'b1;
      do begin @(negedge clk_i); t++; if (rx_ready_o) rdy_bad++; end while (!tx_valid_o && t < 50);
      if (!tx_valid_o) begin
        checks++; errors++; $display("FAIL tx_timeout byte %0d valid=0 required=1", i);
        tx_ready_i = 1'b1; return;
      end
      if (i == 0) lat = t;
      if (i == stall_idx) begin
        d0 = tx_data_o;
        repeat (5) begin
          @(posedge clk_i); #1; @(negedge clk_i);
          if (tx_data_o !== d0 || !tx_valid_o || rx_ready_o) stall_bad++;
        end
        @(posedge clk_i); #1; tx_ready_i = 1'b1;
      end
      @(posedge clk_i); #1;
    end
    tx_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_valid_i = 1'($urandom_range(0, 1)); rx_data_i = 8'($urandom);
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    checks++; if (rx_ready_o !== 1'b0) begin errors++; $display("FAIL rst_rx_ready got %b exp 0", rx_ready_o); end
    checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid_o); end
    checks++; if (tx_data_o !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h exp 00", tx_data_o); end
    checks++; if (ram_clke_o !== 1'b0 || ram_we_o !== 1'b0) begin errors++; $display("FAIL rst_ram_strobe got %b%b exp 00", ram_clke_o, ram_we_o); end
    checks++; if (ram_addr_o !== '0 || ram_wdata_o !== 8'h00) begin errors++; $display("FAIL rst_ram_bus got %h/%h exp 0/00", ram_addr_o, ram_wdata_o); end
    checks++; if (ram_mask_o !== 8'h00) begin errors++; $display("FAIL rst_mask got %h exp 00", ram_mask_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_o); end
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0; rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (rx_ready_o !== 1'b1) begin errors++; $display("FAIL rel_rx_ready got %b exp 1", rx_ready_o); end
    rx_idle(2);
  endtask

  task automatic test_write();
    logic [7:0] pay [4];
    int wb, rb;
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC; pay[3] = 8'hDD;
    wb = wr_a_q.size(); rb = rxh_q.size();
    send_hdr(8'h57, 16'h0010, 16'h0004);
    for (int i = 0; i < 4; i++) send_byte(pay[i]);
    rx_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL wr_busy_fall got %b exp 0", busy_o); end
    rx_idle(3);
    for (int i = 0; i < 4; i++) ref_mem[(16'h10 + i) % VL] = pay[i];
    checks++; if (wr_a_q.size() - wb != 4 || rxh_q.size() - rb != 9) begin
      errors++; $display("FAIL wr_count got %0d/%0d exp 4/9", wr_a_q.size() - wb, rxh_q.size() - rb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (wr_a_q[wb+i] != 16'h10 + i) begin errors++; $display("FAIL wr_addr%0d got %h exp %h", i, wr_a_q[wb+i], 16'h10 + i); end
        checks++; if (wr_d_q[wb+i] != int'(pay[i])) begin errors++; $display("FAIL wr_data%0d got %h exp %h", i, wr_d_q[wb+i], pay[i]); end
        checks++; if (wr_c_q[wb+i] != rxh_q[rb+5+i] + 1) begin errors++; $display("FAIL wr_lag%0d got %0d exp %0d", i, wr_c_q[wb+i], rxh_q[rb+5+i] + 1); end
      end
    end
    checks++; if (mask_bad != 0) begin errors++; $display("FAIL wr_mask got %0d bad cycles exp 0", mask_bad); end
  endtask

  task automatic test_read();
    int tb, wb, lat, sb, rdb;
    tb = tx_q.size(); wb = wr_a_q.size();
    send_hdr(8'h52, 16'h0010, 16'h0004);
    rx_valid_i = 1'b0;
    run_read(4, 1, lat, sb, rdb);
    rx_idle(3);
    checks++; if (tx_q.size() - tb != 4) begin errors++; $display("FAIL rd_count got %0d exp 4", tx_q.size() - tb); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (tx_q[tb+i] != int'(ref_mem[16'h10 + i])) begin errors++; $display("FAIL rd_data%0d got %h exp %h", i, tx_q[tb+i], ref_mem[16'h10 + i]); end
    end
    checks++; if (lat != 3) begin errors++; $display("FAIL rd_latency got %0d exp 3", lat); end
    checks++; if (sb != 0) begin errors++; $display("FAIL rd_stall_stable got %0d bad exp 0", sb); end
    checks++; if (rdb != 0) begin errors++; $display("FAIL rd_rx_ready got %0d high exp 0", rdb); end
    checks++; if (wr_a_q.size() != wb) begin errors++; $display("FAIL rd_no_write got %0d exp 0", wr_a_q.size() - wb); end
  endtask

  task automatic test_wrap();
    int wb;
    wb = wr_a_q.size();
    send_hdr(8'h57, 16'h01FF, 16'h0002); send_byte(8'h11); send_byte(8'h22);
    rx_idle(6);
    send_hdr(8'h57, 16'h03FF, 16'h0001); send_byte(8'h33);
    rx_idle(6);
    ref_mem[start_of(16'h01FF)] = 8'h11; ref_mem[(start_of(16'h01FF) + 1) % VL] = 8'h22; ref_mem[start_of(16'h03FF)] = 8'h33;
    checks++; if (wr_a_q.size() - wb != 3) begin errors++; $display("FAIL wrap_count got %0d exp 3", wr_a_q.size() - wb); end
    else begin
      checks++; if (wr_a_q[wb] != 9'h1FF || wr_d_q[wb] != 8'h11) begin errors++; $display("FAIL wrap_w0 got %h/%h exp 1ff/11", wr_a_q[wb], wr_d_q[wb]); end
      checks++; if (wr_a_q[wb+1] != 0 || wr_d_q[wb+1] != 8'h22) begin errors++; $display("FAIL wrap_w1 got %h/%h exp 000/22", wr_a_q[wb+1], wr_d_q[wb+1]); end
      checks++; if (wr_a_q[wb+2] != 9'h1FF || wr_d_q[wb+2] != 8'h33) begin errors++; $display("FAIL wrap_mask got %h/%h exp 1ff/33", wr_a_q[wb+2], wr_d_q[wb+2]); end
    end
  endtask

  task automatic test_degenerate();
    int sb0, tb, rb, lat, sb, rdb;
    sb0 = strobes; tb = tx_q.size(); rb = rxh_q.size();
    send_byte(8'h00);
    send_hdr(8'h57, 16'h0000, 16'h0000);
    send_hdr(8'h52, 16'h0000, 16'h0000);
    rx_idle(6);
    checks++; if (strobes != sb0) begin errors++; $display("FAIL degen_strobe got %0d exp 0", strobes - sb0); end
    checks++; if (tx_q.size() != tb) begin errors++; $display("FAIL degen_tx got %0d exp 0", tx_q.size() - tb); end
    checks++; if (rxh_q.size() - rb != 11) begin errors++; $display("FAIL degen_consumed got %0d exp 11", rxh_q.size() - rb); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL degen_busy got %b exp 0", busy_o); end
    send_hdr(8'h52, 16'h0010, 16'h0001);
    rx_valid_i = 1'b0;
    run_read(1, -1, lat, sb, rdb);
    rx_idle(3);
    checks++; if (tx_q.size() - tb != 1 || tx_q[tx_q.size()-1] != int'(ref_mem[16'h10])) begin
      errors++; $display("FAIL degen_follow got n=%0d exp one byte %h", tx_q.size() - tb, ref_mem[16'h10]);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] b0, b1;
    int wb, tb, lat, sb, rdb;
    b0 = 8'($urandom); b1 = 8'($urandom);
    wb = wr_a_q.size();
    send_hdr(8'h57, 16'h0020, 16'h0004); send_byte(b0); send_byte(b1);
    rx_valid_i = 1'b0;
    @(posedge clk_i); #1; rst_i = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    rst_i = 1'b0;
    @(negedge clk_i);
    ref_mem[16'h20] = b0; ref_mem[16'h21] = b1;
    checks++; if (wr_a_q.size() - wb != 2) begin errors++; $display("FAIL mid_wr_count got %0d exp 2", wr_a_q.size() - wb); end
    checks++; if (busy_o !== 1'b0 || rx_ready_o !== 1'b1) begin errors++; $display("FAIL mid_idle got busy=%b rdy=%b exp 0/1", busy_o, rx_ready_o); end
    checks++; if (we_in_rst != 0) begin errors++; $display("FAIL we_during_reset got %0d exp 0", we_in_rst); end
    rx_idle(2);
    tb = tx_q.size();
    send_hdr(8'h52, 16'h0020, 16'h0002);
    rx_valid_i = 1'b0;
    run_read(2, -1, lat, sb, rdb);
    rx_idle(3);
    checks++; if (tx_q.size() - tb != 2 || tx_q[tb] != int'(b0) || tx_q[tb+1] != int'(b1)) begin
      errors++; $display("FAIL mid_readback got n=%0d exp %h %h", tx_q.size() - tb, b0, b1);
    end
    // Reset while a read byte is being presented must drop tx_valid.
    send_hdr(8'h52, 16'h0020, 16'h0002);
    rx_valid_i = 1'b0; tx_ready_i = 1'b0;
    repeat (4) begin @(posedge clk_i); #1; end
    rst_i = 1'b1;
    @(posedge clk_i); #1; @(negedge clk_i);
    checks++; if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rd_abort got valid=%b busy=%b exp 0/0", tx_valid_o, busy_o); end
    @(posedge clk_i); #1; rst_i = 1'b0; tx_ready_i = 1'b1;
    rx_idle(2);
  endtask

  task automatic test_random();
    logic [7:0] pay [$];
    for (int it = 0; it < 24; it++) begin
      int a16, len, st, wb, tb, t;
      bit is_wr;
      is_wr = 1'($urandom_range(0, 1)); a16 = int'($urandom_range(0, 65535)); len = int'($urandom_range(0, 6));
      st = start_of(a16); wb = wr_a_q.size(); tb = tx_q.size(); pay.delete();
      send_hdr(is_wr ? 8'h57 : 8'h52, 16'(a16), 16'(len));
      if (is_wr) begin
        for (int i = 0; i < len; i++) begin
          pay.push_back(8'($urandom));
          if ($urandom_range(0, 2) == 0) rx_idle(1);
          send_byte(pay[i]);
        end
        rx_idle(6);
        checks++; if (wr_a_q.size() - wb != len) begin errors++; $display("FAIL rnd%0d_wr_count got %0d exp %0d", it, wr_a_q.size() - wb, len); end
        else for (int i = 0; i < len; i++) begin
          checks++;
          if (wr_a_q[wb+i] != (st + i) % VL || wr_d_q[wb+i] != int'(pay[i])) begin
            errors++; $display("FAIL rnd%0d_wr%0d got %h/%h exp %h/%h", it, i, wr_a_q[wb+i], wr_d_q[wb+i], (st + i) % VL, pay[i]);
          end
        end
        for (int i = 0; i < len; i++) ref_mem[(st + i) % VL] = pay[i];
      end else begin
        rx_valid_i = 1'b0; t = 0;
        while ((tx_q.size() - tb < len || busy_o) && t < 40 * len + 20) begin
          @(posedge clk_i); #1; tx_ready_i = 1'($urandom_range(0, 1)); t++;
        end
        tx_ready_i = 1'b1;
        rx_idle(6);
        checks++; if (tx_q.size() - tb != len) begin errors++; $display("FAIL rnd%0d_rd_count got %0d exp %0d", it, tx_q.size() - tb, len); end
        else for (int i = 0; i < len; i++) begin
          checks++;
          if (tx_q[tb+i] != int'(ref_mem[(st + i) % VL])) begin
            errors++; $display("FAIL rnd%0d_rd%0d got %h exp %h", it, i, tx_q[tb+i], ref_mem[(st + i) % VL]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_degenerate();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
